// File: rtl/if_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer
// (master) and the instruction memory (slave).
interface if_fetch_buffer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: one outstanding imem request, DEPTH-entry instruction FIFO.
// Define IFB_MISALIGN_EN to add misaligned-PC fault entries (if_fault).
module if_fetch_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic        pc_write,
   input  logic        flush,
   if_fetch_buffer_if.master imem,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
`ifdef IFB_MISALIGN_EN
   output logic        if_fault,
`endif
   input  logic        id_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [31:0]   pend_pc_q;

   logic [31:0] mem_pc    [DEPTH];
   logic [31:0] mem_instr [DEPTH];

   logic [31:0] head_pc_q, head_pc_d;
   logic [31:0] head_instr_q, head_instr_d;
   logic        load_head;

   logic        room;
   logic        issue_ok;
   logic        misalign;
   logic        halted;
   logic        accept;
   logic        rsp_push;
   logic        fault_push;
   logic        push;
   logic        pop;
   logic [31:0] push_pc;
   logic [31:0] push_instr;

`ifdef IFB_MISALIGN_EN
   logic mem_fault [DEPTH];
   logic head_fault_q, head_fault_d;
   logic halt_q;

   assign misalign = (pc_in[1:0] != 2'b00);
   assign halted   = halt_q;
   assign if_fault = if_valid & head_fault_q;
`else
   assign misalign = 1'b0;
   assign halted   = 1'b0;
`endif

   assign if_pc    = head_pc_q;
   assign if_instr = head_instr_q;

   always_comb begin
      room       = (count_q < CW'(DEPTH));
      issue_ok   = ~reset & ~flush & room & ~halted & (state_q == IDLE);
      imem.imem_req  = issue_ok & ~misalign;
      imem.imem_addr = pc_in;
      fault_push = issue_ok & misalign;
      accept     = imem.imem_req & imem.imem_ready;
      pc_write   = ~reset & (accept | flush);
      if_valid   = ~reset & (count_q != '0);
      rsp_push   = (state_q == WAIT) & imem.imem_rvalid & ~flush;
      push       = rsp_push | fault_push;
      pop        = if_valid & id_ready & ~flush;
      push_pc    = fault_push ? pc_in : pend_pc_q;
      push_instr = fault_push ? 32'h0 : imem.imem_rdata;
   end

   // Flush wins over any same-cycle push or pop.
   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
      rd_d    = pop  ? rd_q + AW'(1) : rd_q;
      wr_d    = push ? wr_q + AW'(1) : wr_q;
      if (flush) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
      end
   end

   // Head registers follow the next head entry; they hold when empty.
   always_comb begin
      load_head    = ~flush & (count_d != '0);
      head_pc_d    = mem_pc[rd_d];
      head_instr_d = mem_instr[rd_d];
`ifdef IFB_MISALIGN_EN
      head_fault_d = mem_fault[rd_d];
`endif
      if (push && (wr_q == rd_d)) begin
         head_pc_d    = push_pc;
         head_instr_d = push_instr;
`ifdef IFB_MISALIGN_EN
         head_fault_d = fault_push;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = WAIT;
         WAIT: begin
            if (imem.imem_rvalid) state_d = IDLE;
            else if (flush)       state_d = DROP;
         end
         DROP: if (imem.imem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         pend_pc_q    <= '0;
         head_pc_q    <= '0;
         head_instr_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         if (accept) pend_pc_q <= pc_in;
         if (push) begin
            mem_pc[wr_q]    <= push_pc;
            mem_instr[wr_q] <= push_instr;
         end
         if (load_head) begin
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
         end
      end
   end

`ifdef IFB_MISALIGN_EN
   // A fault entry stops issue until the redirect arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         halt_q       <= 1'b0;
         head_fault_q <= 1'b0;
      end else begin
         if (flush)           halt_q <= 1'b0;
         else if (fault_push) halt_q <= 1'b1;
         if (push)      mem_fault[wr_q] <= fault_push;
         if (load_head) head_fault_q    <= head_fault_d;
      end
   end
`endif

endmodule
